// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: holds the decoded pair, checks it against a register
// scoreboard and routes slot 1 / slot 2 onto pipe A (ALU/BRANCH) and pipe B (ALU/MEM).
module issue_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       stop,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       in2_valid,
    input  logic [4:0] in1_rs1,
    input  logic [4:0] in1_rs2,
    input  logic [4:0] in1_rd,
    input  logic       in1_use_rs1,
    input  logic       in1_use_rs2,
    input  logic       in1_wen,
    input  logic [1:0] in1_cls,
    input  logic [4:0] in2_rs1,
    input  logic [4:0] in2_rs2,
    input  logic [4:0] in2_rd,
    input  logic       in2_use_rs1,
    input  logic       in2_use_rs2,
    input  logic       in2_wen,
    input  logic [1:0] in2_cls,
    input  logic       wb0_en,
    input  logic [4:0] wb0_rd,
    input  logic       wb1_en,
    input  logic [4:0] wb1_rd,
    output logic       in_ready,
    output logic       issue_a_valid,
    output logic       issue_a_slot,
    output logic       issue_b_valid,
    output logic       issue_b_slot,
    output logic [3:0] l_flag
);

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_BR  = 2'b01;
    localparam logic [1:0] CLS_MEM = 2'b10;
    localparam logic [1:0] CLS_SYS = 2'b11;

    typedef enum logic {ST_PAIR = 1'b0, ST_SECOND = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [31:1] busy_q, busy_d;

    logic [31:0] busy_full;
    logic        sb_idle, go;
    logic        haz1, haz2, intra_dep, s1_to_b, s2_fits;
    logic        s1_ok, dual_ok, solo2_ok;
    logic        issue1, issue2;

    // Hazard and pairing decision; registered scoreboard only, no writeback bypass.
    always_comb begin
        busy_full = {busy_q, 1'b0};
        sb_idle   = (busy_q == 31'd0);
        go        = !stop && !flush && !rst;
        haz1 = (in1_use_rs1 && busy_full[in1_rs1]) || (in1_use_rs2 && busy_full[in1_rs2]) ||
               (in1_wen && (in1_rd != 5'd0) && busy_full[in1_rd]);
        haz2 = (in2_use_rs1 && busy_full[in2_rs1]) || (in2_use_rs2 && busy_full[in2_rs2]) ||
               (in2_wen && (in2_rd != 5'd0) && busy_full[in2_rd]);
        intra_dep = in1_wen && (in1_rd != 5'd0) &&
                    ((in2_use_rs1 && (in2_rs1 == in1_rd)) ||
                     (in2_use_rs2 && (in2_rs2 == in1_rd)) ||
                     (in2_wen && (in2_rd == in1_rd)));
        // ALU yields pipe A to a following branch so both can go together.
        s1_to_b = (in1_cls == CLS_MEM) ||
                  ((in1_cls == CLS_ALU) && in2_valid && (in2_cls == CLS_BR));
        s2_fits = s1_to_b ? ((in2_cls == CLS_ALU) || (in2_cls == CLS_BR))
                          : ((in2_cls == CLS_ALU) || (in2_cls == CLS_MEM));
        s1_ok    = go && in_valid && !haz1 && ((in1_cls != CLS_SYS) || sb_idle);
        dual_ok  = s1_ok && in2_valid && !haz2 && !intra_dep && s2_fits &&
                   (in1_cls != CLS_BR) && (in1_cls != CLS_SYS) && (in2_cls != CLS_SYS);
        solo2_ok = go && in_valid && !haz2 && ((in2_cls != CLS_SYS) || sb_idle);
        issue1   = (state_q == ST_PAIR) && s1_ok;
        issue2   = ((state_q == ST_PAIR) && dual_ok) || ((state_q == ST_SECOND) && solo2_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PAIR;
            busy_q  <= 31'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_PAIR;
        end else begin
            case (state_q)
                ST_PAIR:   if (issue1 && in2_valid && !issue2) state_d = ST_SECOND;
                ST_SECOND: if (issue2) state_d = ST_PAIR;
                default:   state_d = ST_PAIR;
            endcase
        end
    end

    always_comb begin
        issue_a_valid = 1'b0;
        issue_a_slot  = 1'b0;
        issue_b_valid = 1'b0;
        issue_b_slot  = 1'b0;
        in_ready      = 1'b0;
        if (state_q == ST_PAIR && s1_ok) begin
            if (s1_to_b) begin
                issue_b_valid = 1'b1;
                if (dual_ok) begin
                    issue_a_valid = 1'b1;
                    issue_a_slot  = 1'b1;
                end
            end else begin
                issue_a_valid = 1'b1;
                if (dual_ok) begin
                    issue_b_valid = 1'b1;
                    issue_b_slot  = 1'b1;
                end
            end
            in_ready = !in2_valid || dual_ok;
        end else if (state_q == ST_SECOND && solo2_ok) begin
            if (in2_cls == CLS_MEM) begin
                issue_b_valid = 1'b1;
                issue_b_slot  = 1'b1;
            end else begin
                issue_a_valid = 1'b1;
                issue_a_slot  = 1'b1;
            end
            in_ready = 1'b1;
        end
        l_flag = {issue_b_valid, issue_b_slot, issue_a_valid, issue_a_slot};
    end

    // Writeback clears first, then issue sets, so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (wb0_en && (wb0_rd != 5'd0)) busy_d[wb0_rd] = 1'b0;
        if (wb1_en && (wb1_rd != 5'd0)) busy_d[wb1_rd] = 1'b0;
        if (issue1 && in1_wen && (in1_rd != 5'd0)) busy_d[in1_rd] = 1'b1;
        if (issue2 && in2_wen && (in2_rd != 5'd0)) busy_d[in2_rd] = 1'b1;
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: each task drives a scenario and checks
// {l_flag, in_ready} against hand-derived values.
module tb_issue_ctrl;

    logic       clk, rst, stop, flush, in_valid, in2_valid;
    logic [4:0] in1_rs1, in1_rs2, in1_rd, in2_rs1, in2_rs2, in2_rd;
    logic       in1_use_rs1, in1_use_rs2, in1_wen, in2_use_rs1, in2_use_rs2, in2_wen;
    logic [1:0] in1_cls, in2_cls;
    logic       wb0_en, wb1_en;
    logic [4:0] wb0_rd, wb1_rd;
    logic       in_ready, issue_a_valid, issue_a_slot, issue_b_valid, issue_b_slot;
    logic [3:0] l_flag;

    int vecs = 0;
    int errs = 0;

    issue_ctrl dut (
        .clk(clk), .rst(rst), .stop(stop), .flush(flush),
        .in_valid(in_valid), .in2_valid(in2_valid),
        .in1_rs1(in1_rs1), .in1_rs2(in1_rs2), .in1_rd(in1_rd),
        .in1_use_rs1(in1_use_rs1), .in1_use_rs2(in1_use_rs2), .in1_wen(in1_wen), .in1_cls(in1_cls),
        .in2_rs1(in2_rs1), .in2_rs2(in2_rs2), .in2_rd(in2_rd),
        .in2_use_rs1(in2_use_rs1), .in2_use_rs2(in2_use_rs2), .in2_wen(in2_wen), .in2_cls(in2_cls),
        .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb1_en(wb1_en), .wb1_rd(wb1_rd),
        .in_ready(in_ready),
        .issue_a_valid(issue_a_valid), .issue_a_slot(issue_a_slot),
        .issue_b_valid(issue_b_valid), .issue_b_slot(issue_b_slot),
        .l_flag(l_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_s1(input logic [1:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2, input logic wen);
        in1_cls = cls; in1_rd = rd; in1_rs1 = rs1; in1_rs2 = rs2;
        in1_use_rs1 = u1; in1_use_rs2 = u2; in1_wen = wen;
    endtask

    task automatic set_s2(input logic [1:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2, input logic wen);
        in2_cls = cls; in2_rd = rd; in2_rs1 = rs1; in2_rs2 = rs2;
        in2_use_rs1 = u1; in2_use_rs2 = u2; in2_wen = wen;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_s1(2'b00, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        set_s2(2'b10, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b1; in2_valid = 1'b1;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL reset_held: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        vecs++; if ({issue_b_valid, issue_b_slot, issue_a_valid, issue_a_slot} !== 4'b0000) begin errs++; $display("FAIL reset_ports: got %b want 0000", {issue_b_valid, issue_b_slot, issue_a_valid, issue_a_slot}); end
        step(); step();
        rst = 1'b0; in_valid = 1'b0; in2_valid = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL reset_idle: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        step();
    endtask

    task automatic test_dual();
        set_s1(2'b00, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
        set_s2(2'b10, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b1; in2_valid = 1'b1;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b11101) begin errs++; $display("FAIL dual_alu_mem: got %b want %b", {l_flag, in_ready}, 5'b11101); end
        step();
        set_s1(2'b00, 5'd0, 5'd1, 5'd3, 1'b1, 1'b1, 1'b0);
        in2_valid = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL dual_busy_set: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        step();
        wb0_en = 1'b1; wb0_rd = 5'd1; wb1_en = 1'b1; wb1_rd = 5'd3;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL dual_wb_cycle: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        step();
        wb0_en = 1'b0; wb1_en = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00101) begin errs++; $display("FAIL dual_after_wb: got %b want %b", {l_flag, in_ready}, 5'b00101); end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_split();
        set_s1(2'b00, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);
        set_s2(2'b00, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b1; in2_valid = 1'b1;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00100) begin errs++; $display("FAIL split_first: got %b want %b", {l_flag, in_ready}, 5'b00100); end
        step();
        wb0_en = 1'b1; wb0_rd = 5'd5;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL split_second_raw: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        step();
        wb0_en = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00111) begin errs++; $display("FAIL split_second: got %b want %b", {l_flag, in_ready}, 5'b00111); end
        step();
        in_valid = 1'b0; in2_valid = 1'b0; wb0_en = 1'b1; wb0_rd = 5'd6;
        step();
        wb0_en = 1'b0;
    endtask

    task automatic test_raw_wb();
        set_s1(2'b00, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1; in2_valid = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00101) begin errs++; $display("FAIL raw_producer: got %b want %b", {l_flag, in_ready}, 5'b00101); end
        step();
        set_s1(2'b00, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL raw_stall: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        step();
        wb0_en = 1'b1; wb0_rd = 5'd7;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL raw_wb_cycle_n: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        step();
        wb0_en = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00101) begin errs++; $display("FAIL raw_issue_n1: got %b want %b", {l_flag, in_ready}, 5'b00101); end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_routing();
        set_s1(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_s2(2'b01, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in2_valid = 1'b1;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b10111) begin errs++; $display("FAIL alu_branch: got %b want %b", {l_flag, in_ready}, 5'b10111); end
        step();
        set_s1(2'b01, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_s2(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00100) begin errs++; $display("FAIL branch_alu_first: got %b want %b", {l_flag, in_ready}, 5'b00100); end
        step();
        vecs++; if ({l_flag, in_ready} !== 5'b00111) begin errs++; $display("FAIL branch_alu_second: got %b want %b", {l_flag, in_ready}, 5'b00111); end
        step();
        in_valid = 1'b0; in2_valid = 1'b0;
    endtask

    task automatic test_sys();
        set_s1(2'b00, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1; in2_valid = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00101) begin errs++; $display("FAIL sys_setup: got %b want %b", {l_flag, in_ready}, 5'b00101); end
        step();
        set_s1(2'b11, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_s2(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        in2_valid = 1'b1;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL sys_wait_busy: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        step();
        wb0_en = 1'b1; wb0_rd = 5'd9;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL sys_wb_cycle: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        step();
        wb0_en = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00100) begin errs++; $display("FAIL sys_issue_alone: got %b want %b", {l_flag, in_ready}, 5'b00100); end
        step();
        vecs++; if ({l_flag, in_ready} !== 5'b00111) begin errs++; $display("FAIL sys_slot2_second: got %b want %b", {l_flag, in_ready}, 5'b00111); end
        step();
        in_valid = 1'b0; in2_valid = 1'b0;
    endtask

    task automatic test_stop();
        set_s1(2'b01, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_s2(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in2_valid = 1'b1;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00100) begin errs++; $display("FAIL stop_setup: got %b want %b", {l_flag, in_ready}, 5'b00100); end
        step();
        stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL stop_hold%0d: got %b want %b", i, {l_flag, in_ready}, 5'b00000); end
            step();
        end
        stop = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00111) begin errs++; $display("FAIL stop_release: got %b want %b", {l_flag, in_ready}, 5'b00111); end
        step();
        in_valid = 1'b0; in2_valid = 1'b0;
    endtask

    task automatic test_flush();
        set_s1(2'b00, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        set_s2(2'b00, 5'd0, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1; in2_valid = 1'b1;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00100) begin errs++; $display("FAIL flush_setup: got %b want %b", {l_flag, in_ready}, 5'b00100); end
        step();
        flush = 1'b1;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL flush_cycle: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        step();
        flush = 1'b0;
        set_s1(2'b00, 5'd0, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
        in2_valid = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL flush_busy_kept: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        set_s1(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_s2(2'b10, 5'd0, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
        in2_valid = 1'b1;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00100) begin errs++; $display("FAIL flush_state_pair: got %b want %b", {l_flag, in_ready}, 5'b00100); end
        step();
        wb0_en = 1'b1; wb0_rd = 5'd10;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL flush_second_raw: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        step();
        wb0_en = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b11001) begin errs++; $display("FAIL flush_mem_second: got %b want %b", {l_flag, in_ready}, 5'b11001); end
        step();
        in_valid = 1'b0; in2_valid = 1'b0;
    endtask

    task automatic test_set_wins();
        set_s1(2'b00, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1; in2_valid = 1'b0;
        wb0_en = 1'b1; wb0_rd = 5'd4;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00101) begin errs++; $display("FAIL setwins_issue: got %b want %b", {l_flag, in_ready}, 5'b00101); end
        step();
        wb0_en = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL setwins_waw: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        set_s1(2'b00, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00000) begin errs++; $display("FAIL setwins_busy4: got %b want %b", {l_flag, in_ready}, 5'b00000); end
        step();
        wb0_en = 1'b1; wb0_rd = 5'd4;
        step();
        wb0_en = 1'b0;
        #1;
        vecs++; if ({l_flag, in_ready} !== 5'b00101) begin errs++; $display("FAIL setwins_cleared: got %b want %b", {l_flag, in_ready}, 5'b00101); end
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stop = 1'b0; flush = 1'b0; in_valid = 1'b0; in2_valid = 1'b0;
        wb0_en = 1'b0; wb0_rd = 5'd0; wb1_en = 1'b0; wb1_rd = 5'd0;
        set_s1(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        set_s2(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        test_reset();
        test_dual();
        test_split();
        test_raw_wb();
        test_routing();
        test_sys();
        test_stop();
        test_flush();
        test_set_wins();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
